// File: rtl/wvb_reader.sv
// wvb_reader: turns one header from a show-ahead header FIFO and the samples it
// points to in the waveform buffer RAM into a 16-bit output word stream.
// Each event goes out as 5 header words followed by n_samples sample words.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   en              allows a new event to start (looked at only while idle)
//   hdr_empty/hdr_data/hdr_rdreq   show-ahead header FIFO
//   wvb_data/wvb_rdreq/wvb_rddone  buffer RAM read port; the buffer side advances
//                   the address on every wvb_rdreq, and data returns P_RD_LAT cycles later
//   dout/dout_valid/dout_ready     output stream (valid/ready handshake)
//   busy            an event is in progress
//   evt_cnt         completed events (wraps)
//   len_err         sticky: eoe flag did not agree with the sample count
module wvb_reader #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_LTC_WIDTH  = 48,
  parameter int P_RD_LAT     = 2,
  parameter int P_SKID_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  output logic [15:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [15:0]             evt_cnt,
  output logic                    len_err
);

  localparam int NW = P_ADR_WIDTH + 1;        // sample count width
  localparam int PW = $clog2(P_SKID_DEPTH);   // skid pointer width
  localparam int LTC_LSB = P_HDR_WIDTH - P_LTC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t state, state_nxt;

  logic [P_HDR_WIDTH-1:0] hdr_q;
  logic [P_ADR_WIDTH-1:0] span;
  logic [NW-1:0]          n_samples, req_cnt, rx_cnt, pop_cnt;
  logic [2:0]             hdr_idx;
  logic [P_RD_LAT-1:0]    vld_pipe;            // one bit per outstanding RAM read
  logic [15:0]            skid_mem [P_SKID_DEPTH];
  logic [PW:0]            wptr, rptr, occ;
  logic [PW+1:0]          inflight, budget;
  logic                   skid_empty, skid_push;
  logic [15:0]            samp_word, src_word;
  logic                   src_valid, out_load, out_last;
  logic                   rx_last, accept;
  logic [P_LTC_WIDTH-1:0] ltc;

  // reserved header bits and the discriminator field are deliberately dropped
  logic unused_bits;
  assign unused_bits = ^{hdr_q[31:28], wvb_data[19:12]};

  assign ltc       = hdr_q[LTC_LSB +: P_LTC_WIDTH];
  assign span      = hdr_q[12 +: P_ADR_WIDTH] - hdr_q[0 +: P_ADR_WIDTH];
  assign n_samples = {1'b0, span} + NW'(1);

  // ---------------- read issue ----------------
  assign occ        = wptr - rptr;
  assign skid_empty = (occ == '0);
  assign skid_push  = vld_pipe[P_RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < P_RD_LAT; i++)
      inflight = inflight + (PW+2)'(vld_pipe[i]);
    budget = (PW+2)'(occ) + inflight;
  end

  // Reads already in flight must always find a free skid slot when they land,
  // so they are charged against the FIFO depth at issue time.
  assign wvb_rdreq = !rst && (state == S_DATA) && (req_cnt < n_samples) &&
                     (budget < (PW+2)'(P_SKID_DEPTH));

  assign samp_word = {wvb_data[20], wvb_data[21], 2'b00, wvb_data[11:0]};
  assign rx_last   = (rx_cnt == n_samples - NW'(1));

  // ---------------- output word source ----------------
  always_comb begin
    src_word  = skid_mem[rptr[PW-1:0]];
    src_valid = 1'b0;
    if (state == S_HDR) begin
      src_valid = 1'b1;
      case (hdr_idx)
        3'd0:    src_word = {8'h90, 4'h0, hdr_q[27], hdr_q[26], hdr_q[25:24]};
        3'd1:    src_word = 16'(n_samples);
        3'd2:    src_word = ltc[47:32];
        3'd3:    src_word = ltc[31:16];
        default: src_word = ltc[15:0];
      endcase
    end else if (state == S_DATA) begin
      src_valid = !skid_empty;
    end
  end

  // The output register refills whenever it is empty or being drained, so
  // header and data words can flow back to back without bubbles.
  assign accept   = dout_valid && dout_ready;
  assign out_load = src_valid && (!dout_valid || dout_ready);

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt  = state;
    hdr_rdreq  = 1'b0;
    wvb_rddone = 1'b0;
    case (state)
      S_IDLE: if (!rst && en && !hdr_empty) begin
        hdr_rdreq = 1'b1;
        state_nxt = S_HDR;
      end
      S_HDR:  if (out_load && hdr_idx == 3'd4) state_nxt = S_DATA;
      S_DATA: if (accept && out_last) state_nxt = S_DONE;
      S_DONE: begin
        wvb_rddone = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hdr_q      <= '0;
      hdr_idx    <= '0;
      req_cnt    <= '0;
      rx_cnt     <= '0;
      pop_cnt    <= '0;
      vld_pipe   <= '0;   // flushing this drops any read data still returning
      wptr       <= '0;
      rptr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      out_last   <= 1'b0;
      evt_cnt    <= '0;
      len_err    <= 1'b0;
    end else begin
      state <= state_nxt;

      vld_pipe[0] <= wvb_rdreq;
      for (int i = 1; i < P_RD_LAT; i++)
        vld_pipe[i] <= vld_pipe[i-1];

      if (hdr_rdreq) begin
        hdr_q   <= hdr_data;
        hdr_idx <= '0;
        req_cnt <= '0;
        rx_cnt  <= '0;
        pop_cnt <= '0;
      end

      if (wvb_rdreq) req_cnt <= req_cnt + NW'(1);

      if (skid_push) begin
        wptr   <= wptr + (PW+1)'(1);
        rx_cnt <= rx_cnt + NW'(1);
        // eoe must be set on the last sample and only there
        if (wvb_data[21] != rx_last) len_err <= 1'b1;
      end

      if (out_load) begin
        dout       <= src_word;
        dout_valid <= 1'b1;
        out_last   <= (state == S_DATA) && (pop_cnt == n_samples - NW'(1));
        if (state == S_HDR) hdr_idx <= hdr_idx + 3'd1;
        if (state == S_DATA) begin
          rptr    <= rptr + (PW+1)'(1);
          pop_cnt <= pop_cnt + NW'(1);
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (state == S_DONE) evt_cnt <= evt_cnt + 16'd1;
    end
  end

  // skid storage needs no reset: pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (skid_push) skid_mem[wptr[PW-1:0]] <= samp_word;
  end

endmodule
